seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed 7-segment display driver for the board's common-anode digit banks. It takes an N-digit hex value with per-digit decimal-point and enable masks through a load strobe and double-buffers them so updates never tear mid-frame. It scans the digits round-robin with a programmable refresh divider and anti-ghost blanking, and decodes each nibble to active-low cathodes. It sits between the filter's status/result registers and the top-level display pins.

## Interface
- DIGITS, 8, number of digits scanned (1..16)
- DIV, 100000, clock cycles per digit slot (>= 2)
- BLANK, 1000, cycles at the start of each slot with all anodes off (0 <= BLANK < DIV)
- clk  input  1  system clock; one clock domain
- rst_n  input  1  asynchronous active-low reset
- value  input  4*DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
- dp_in  input  DIGITS  decimal-point request per digit, 1 = lit
- en_in  input  DIGITS  digit enable, 0 = digit forced dark
- load  input  1  one-cycle strobe capturing value/dp_in/en_in into the shadow buffer
- lzb  input  1  leading-zero blanking mode, sampled live
- seg  output  7  cathodes {a,b,c,d,e,f,g}, active low
- dp  output  1  decimal-point cathode, active low
- an  output  DIGITS  anodes, active low, at most one low at any time
- frame_tick  output  1  one-cycle pulse at each frame boundary

## Operation
- Prescaler cnt counts 0..DIV-1. At cnt==DIV-1, cnt->0 and digit index idx advances, wrapping DIGITS-1 -> 0.
- Frame boundary is the edge where cnt==DIV-1 and idx==DIGITS-1. At that edge, if pending==1, the display buffer takes the shadow buffer and pending clears. frame_tick is high for the following cycle.
- load=1 writes the shadow buffer and sets pending.
- load coincident with a frame boundary: the transfer uses the pre-edge shadow contents. The new data lands in the shadow and pending stays 1, so it is displayed from the next frame.
- Decode, active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blanking (lzb=1): digit i is blanked when its nibble and all nibbles above it are 0. Digit 0 is never blanked by lzb. A blanked digit still honours its dp bit.
- Digit dark (en=0): an bit stays high for the whole slot. seg and dp are 1111111/1.
- Blank window (cnt < BLANK): all an=1 and seg=1111111, dp=1.
- No other data path. Display buffer contents change only at a frame boundary.

## Timing
- Reset (async assert): cnt=0, idx=0, pending=0, shadow and display buffers cleared, en=0, dp=0.
- During reset: seg=1111111, dp=1, an all 1, frame_tick=0. The display stays dark until the first load reaches the display buffer.
- Outputs are registered with one-cycle latency from the (cnt, idx, buffer) state. In slot k, an[k] is low for cycles BLANK+1..DIV of the slot, counted from the slot's first edge.
- Frame period = DIGITS*DIV cycles. Load-to-display latency ranges from 1 cycle up to one full frame, plus 1 cycle.
- Reset mid-frame: everything returns to reset values immediately. Scanning restarts at digit 0 on the first edge after deassertion.
- lzb change takes effect on the next cycle's registered outputs, with no frame sync.

## Test plan
Bench parameters: DIGITS=4, DIV=4, BLANK=1.

- Reset, then 40 cycles idle -> an=1111 throughout, seg=1111111, dp=1. frame_tick pulses every 16 cycles.
- load value=16'h1A2F, en=1111, dp=0100 -> after the next frame_tick, slots show:
  - digit0: seg=0111000
  - digit1: seg=0010010
  - digit2: seg=0001000, dp=0
  - digit3: seg=1001111
  - each an low for 3 of 4 cycles, with exactly one an low at a time.
- lzb=1, display 16'h0030 -> digits 3,2 dark, digit1 seg=0000110, digit0 seg=0000001. With 16'h0000, only digit0 lit.
- load 16'h1111 on the frame-boundary edge, then load 16'h2222 mid-frame -> the old value holds for that frame, the next frame shows 2222, and 1111 is never displayed.
- en=1010 -> an[0] and an[2] never low. The other slots decode normally.
- Assert rst_n=0 mid-slot for 1 cycle -> outputs go dark asynchronously. After release the display stays dark (buffers cleared), and scanning restarts at digit 0 with frame_tick 16 cycles later.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: load/data inputs from the register
// block and the multiplexed cathode/anode pins back out.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   en_in;
    logic                load;
    logic                lzb;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_tick;

    modport master (
        output value, dp_in, en_in, load, lzb,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  value, dp_in, en_in, load, lzb,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadow/display double buffer,
// round-robin digit scan with anti-ghost blanking, hex decode to active-low cathodes.
module seg7_scan_driver #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int BLANK  = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF   = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] sh_val_q, sh_val_d, dy_val_q, dy_val_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, dy_dp_q, dy_dp_d;
    logic [DIGITS-1:0]   sh_en_q, sh_en_d, dy_en_q, dy_en_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                tick_q, tick_d;

    logic                slot_end;
    logic                frame_end;
    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          cur_nib;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign cur_nib   = dy_val_q[{idx_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 is excluded so a zero value still shows a single "0".
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (dy_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        pend_d   = pend_q;
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_en_d  = sh_en_q;
        dy_val_d = dy_val_q;
        dy_dp_d  = dy_dp_q;
        dy_en_d  = dy_en_q;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        an_d     = '1;
        tick_d   = frame_end;

        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Transfer reads the pre-edge shadow; a coincident load is applied after
        // and re-arms pending, so it shows from the following frame.
        if (frame_end && pend_q) begin
            dy_val_d = sh_val_q;
            dy_dp_d  = sh_dp_q;
            dy_en_d  = sh_en_q;
            pend_d   = 1'b0;
        end
        if (bus.load) begin
            sh_val_d = bus.value;
            sh_dp_d  = bus.dp_in;
            sh_en_d  = bus.en_in;
            pend_d   = 1'b1;
        end

        if ((cnt_q >= CNT_BLANK) && dy_en_q[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = (bus.lzb && lz_mask[idx_q]) ? SEG_OFF : hex_to_seg(cur_nib);
            dp_d        = ~dy_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffers are plain flop arrays, not RAM, so they take reset; the display must come up dark.
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            dy_val_q <= '0;
            dy_dp_q  <= '0;
            dy_en_q  <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            an_q     <= '1;
            tick_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the same pre-edge state.
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            sh_val_q <= sh_val_d;
            sh_dp_q  <= sh_dp_d;
            sh_en_q  <= sh_en_d;
            dy_val_q <= dy_val_d;
            dy_dp_q  <= dy_dp_d;
            dy_en_q  <= dy_en_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, DIV=4, BLANK=1): a vector table
// of whole-frame expectations plus hand sequences for load timing and reset.
module tb_seg7_scan_driver;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;
    localparam int FRAME  = DIGITS * DIV;

    localparam logic [6:0] S_0   = 7'b0000001;
    localparam logic [6:0] S_1   = 7'b1001111;
    localparam logic [6:0] S_2   = 7'b0010010;
    localparam logic [6:0] S_3   = 7'b0000110;
    localparam logic [6:0] S_4   = 7'b1001100;
    localparam logic [6:0] S_5   = 7'b0100100;
    localparam logic [6:0] S_6   = 7'b0100000;
    localparam logic [6:0] S_7   = 7'b0001111;
    localparam logic [6:0] S_8   = 7'b0000000;
    localparam logic [6:0] S_9   = 7'b0000100;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_B   = 7'b1100000;
    localparam logic [6:0] S_C   = 7'b0110001;
    localparam logic [6:0] S_D   = 7'b1000010;
    localparam logic [6:0] S_E   = 7'b0110000;
    localparam logic [6:0] S_F   = 7'b0111000;
    localparam logic [6:0] S_OFF = 7'b1111111;

    typedef struct {
        logic        do_load;
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  en_in;
        logic        lzb;
        logic [27:0] seg_exp;   // digit k at [7k+6:7k]
        logic [3:0]  dp_exp;    // active-low cathode while digit k is lit
        logic [3:0]  lit_exp;   // digits whose anode should ever go low
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [10];
    vec_t v_2222;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [15:0] val, input logic [3:0] dpi,
                                input logic [3:0] eni, input logic lz, input logic [27:0] segx,
                                input logic [3:0] dpx, input logic [3:0] litx);
        vec_t v;
        v.do_load = ld;
        v.value   = val;
        v.dp_in   = dpi;
        v.en_in   = eni;
        v.lzb     = lz;
        v.seg_exp = segx;
        v.dp_exp  = dpx;
        v.lit_exp = litx;
        return v;
    endfunction

    // Display must be dark; frame_tick on every FRAME-th cycle counted from the start point.
    task automatic idle_run(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check("idle_an", 32'(bus.an), 32'hF);
            check("idle_seg", 32'(bus.seg), 32'(S_OFF));
            check("idle_dp", 32'(bus.dp), 32'd1);
            check("idle_tick", 32'(bus.frame_tick), 32'((i % FRAME) == 0));
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_tick;
        end
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
    endtask

    // Samples the FRAME cycles following a frame_tick cycle; optionally pulses
    // a load of load_val after sample load_at.
    task automatic collect_frame(input string tag, input vec_t v, input int load_at,
                                 input logic [15:0] load_val);
        int lit_cnt [DIGITS];
        int last_k;
        int k;
        for (int d = 0; d < DIGITS; d++) lit_cnt[d] = 0;
        last_k = 0;
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk);
            check({tag, "_onehot"}, 32'($countones(~bus.an) <= 1), 32'd1);
            k = -1;
            for (int d = 0; d < DIGITS; d++) if (!bus.an[d]) k = d;
            if (k >= 0) begin
                lit_cnt[k]++;
                check({tag, "_order"}, 32'(k >= last_k), 32'd1);
                last_k = k;
                check($sformatf("%s_seg%0d", tag, k), 32'(bus.seg), 32'(v.seg_exp[7*k +: 7]));
                check($sformatf("%s_dp%0d", tag, k), 32'(bus.dp), 32'(v.dp_exp[k]));
            end else begin
                check({tag, "_dark_seg"}, 32'(bus.seg), 32'(S_OFF));
                check({tag, "_dark_dp"}, 32'(bus.dp), 32'd1);
            end
            if (j == load_at) begin
                bus.value = load_val;
                bus.load  = 1'b1;
            end
            if (j == load_at + 1) bus.load = 1'b0;
        end
        for (int d = 0; d < DIGITS; d++)
            check($sformatf("%s_lit%0d", tag, d), 32'(lit_cnt[d]),
                  32'(v.lit_exp[d] ? (DIV - BLANK) : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lit_seen;

        vecs[0] = mk(1'b1, 16'h1A2F, 4'b0100, 4'b1111, 1'b0, {S_1, S_A, S_2, S_F}, 4'b1011, 4'b1111);
        vecs[1] = mk(1'b1, 16'h0030, 4'b0000, 4'b1111, 1'b1, {S_OFF, S_OFF, S_3, S_0}, 4'b1111, 4'b1111);
        vecs[2] = mk(1'b0, 16'h0000, 4'b0000, 4'b1111, 1'b0, {S_0, S_0, S_3, S_0}, 4'b1111, 4'b1111);
        vecs[3] = mk(1'b1, 16'h0000, 4'b0000, 4'b1111, 1'b1, {S_OFF, S_OFF, S_OFF, S_0}, 4'b1111, 4'b1111);
        vecs[4] = mk(1'b1, 16'h0005, 4'b1000, 4'b1111, 1'b1, {S_OFF, S_OFF, S_OFF, S_5}, 4'b0111, 4'b1111);
        vecs[5] = mk(1'b1, 16'h0900, 4'b0000, 4'b1111, 1'b1, {S_OFF, S_9, S_0, S_0}, 4'b1111, 4'b1111);
        vecs[6] = mk(1'b1, 16'h089B, 4'b0000, 4'b1111, 1'b1, {S_OFF, S_8, S_9, S_B}, 4'b1111, 4'b1111);
        vecs[7] = mk(1'b1, 16'hCDE4, 4'b0001, 4'b1111, 1'b0, {S_C, S_D, S_E, S_4}, 4'b1110, 4'b1111);
        vecs[8] = mk(1'b1, 16'h1A2F, 4'b0101, 4'b1010, 1'b0, {S_1, S_OFF, S_2, S_OFF}, 4'b1111, 4'b1010);
        vecs[9] = mk(1'b1, 16'h3657, 4'b1111, 4'b1111, 1'b0, {S_3, S_6, S_5, S_7}, 4'b0000, 4'b1111);
        v_2222  = mk(1'b1, 16'h2222, 4'b0000, 4'b1111, 1'b0, {S_2, S_2, S_2, S_2}, 4'b1111, 4'b1111);

        bus.value = '0;
        bus.dp_in = '0;
        bus.en_in = '0;
        bus.load  = 1'b0;
        bus.lzb   = 1'b0;

        // Reset state, then idle scanning with an empty display buffer.
        repeat (3) @(negedge clk);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_seg", 32'(bus.seg), 32'(S_OFF));
        check("rst_dp", 32'(bus.dp), 32'd1);
        check("rst_tick", 32'(bus.frame_tick), 32'd0);
        rst_n = 1'b1;
        idle_run(40);

        // Vector table: load (or just change lzb), let two frames pass, check one frame.
        for (int i = 0; i < 10; i++) begin
            bus.lzb = vecs[i].lzb;
            if (vecs[i].do_load) begin
                bus.value = vecs[i].value;
                bus.dp_in = vecs[i].dp_in;
                bus.en_in = vecs[i].en_in;
                bus.load  = 1'b1;
                @(negedge clk);
                bus.load  = 1'b0;
            end
            wait_tick();
            wait_tick();
            collect_frame($sformatf("vec%0d", i), vecs[i], -1, 16'h0000);
        end

        // Load on the frame-boundary edge, then overwrite mid-frame: the old value
        // holds one more frame, 2222 follows, 1111 never appears.
        wait_tick();
        repeat (FRAME - 1) @(negedge clk);
        bus.value = 16'h1111;
        bus.dp_in = 4'b0000;
        bus.en_in = 4'b1111;
        bus.load  = 1'b1;
        @(negedge clk);
        check("coincident_tick", 32'(bus.frame_tick), 32'd1);
        bus.load = 1'b0;
        collect_frame("hold_old", vecs[9], 4, 16'h2222);
        collect_frame("show_new", v_2222, -1, 16'h0000);

        // Asynchronous reset in the middle of a lit slot.
        lit_seen = 1'b0;
        for (int i = 0; i < 2 * DIV && !lit_seen; i++) begin
            @(negedge clk);
            lit_seen = (bus.an != 4'hF);
        end
        check("pre_reset_lit", 32'(lit_seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(bus.an), 32'hF);
        check("async_rst_seg", 32'(bus.seg), 32'(S_OFF));
        check("async_rst_dp", 32'(bus.dp), 32'd1);
        check("async_rst_tick", 32'(bus.frame_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_run(3 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
